// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch, memory-wait
// and halt requests into one per-cycle action, plus a stall watchdog and perf counters.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_LIMIT  = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hasHazard,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             halt,
  output logic             PCWrite,
  output logic             IF_ID_Hold,
  output logic             IF_ID_Flush,
  output logic             ID_EX_CtrlFlush,
  output logic             ID_EX_Hold,
  output logic             EX_MEM_Hold,
  output logic             halted,
  output logic             stall_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_e;
  typedef enum logic [2:0] {
    ACT_RESET, ACT_HALT, ACT_MEMWAIT, ACT_FLUSH, ACT_STALL, ACT_RUN
  } action_e;

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0]       STALL_LIM    = 4'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_e           state_q, state_d;
  action_e          action;
  logic [2:0]       flush_left_q, flush_left_d;
  logic             branch_pend_q, branch_pend_d;
  logic [3:0]       stall_run_q, stall_run_d;
  logic             stall_error_q, stall_error_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    if (reset)                                         action = ACT_RESET;
    else if (state_q == ST_HALT || halt)               action = ACT_HALT;
    else if (mem_busy)                                 action = ACT_MEMWAIT;
    else if (state_q == ST_FLUSH || branch_taken || branch_pend_q)
                                                       action = ACT_FLUSH;
    else if (hasHazard)                                action = ACT_STALL;
    else                                               action = ACT_RUN;
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    PCWrite         = 1'b0;
    IF_ID_Hold      = 1'b0;
    IF_ID_Flush     = 1'b0;
    ID_EX_CtrlFlush = 1'b0;
    ID_EX_Hold      = 1'b0;
    EX_MEM_Hold     = 1'b0;
    halted          = 1'b0;
    unique case (action)
      ACT_RUN:     PCWrite = 1'b1;
      ACT_STALL:   begin IF_ID_Hold = 1'b1; ID_EX_CtrlFlush = 1'b1; end
      ACT_MEMWAIT: begin IF_ID_Hold = 1'b1; ID_EX_Hold = 1'b1; EX_MEM_Hold = 1'b1; end
      ACT_FLUSH:   begin PCWrite = 1'b1; IF_ID_Flush = 1'b1; ID_EX_CtrlFlush = 1'b1; end
      ACT_HALT:    begin IF_ID_Hold = 1'b1; ID_EX_CtrlFlush = 1'b1; halted = 1'b1; end
      ACT_RESET:   begin IF_ID_Flush = 1'b1; ID_EX_CtrlFlush = 1'b1; end
      default:     ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    flush_left_d   = flush_left_q;
    branch_pend_d  = branch_pend_q;
    stall_run_d    = stall_run_q;
    stall_error_d  = stall_error_q;
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    unique case (action)
      ACT_HALT:    state_d = ST_HALT;
      ACT_MEMWAIT: if (branch_taken) branch_pend_d = 1'b1;
      ACT_FLUSH: begin
        stall_run_d = 4'd0;
        // A branch left pending by a mid-flush memory wait restarts the count like a fresh pulse.
        if (state_q != ST_FLUSH || branch_taken || branch_pend_q) begin
          flush_left_d  = FLUSH_RELOAD;
          branch_pend_d = 1'b0;
          if (flush_events_q != CNT_MAX) flush_events_d = flush_events_q + 1'b1;
          state_d = (FLUSH_RELOAD == 3'd0) ? ST_RUN : ST_FLUSH;
        end else begin
          flush_left_d = flush_left_q - 3'd1;
          if (flush_left_q == 3'd1) state_d = ST_RUN;
        end
      end
      ACT_STALL: begin
        if (stall_run_q != 4'hF) stall_run_d = stall_run_q + 4'd1;
        if (stall_cycles_q != CNT_MAX) stall_cycles_d = stall_cycles_q + 1'b1;
        if (stall_run_d == STALL_LIM) stall_error_d = 1'b1;
      end
      ACT_RUN: stall_run_d = 4'd0;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RUN;
      flush_left_q   <= 3'd0;
      branch_pend_q  <= 1'b0;
      stall_run_q    <= 4'd0;
      stall_error_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_left_q   <= flush_left_d;
      branch_pend_q  <= branch_pend_d;
      stall_run_q    <= stall_run_d;
      stall_error_q  <= stall_error_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_error  = stall_error_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule
